cam_param: RTL and testbench

- Parametrised successor to the team's 16x8 search CAM.
- Adds configurable width and depth, per-entry valid bits, invalidate and flush operations, a lowest-index priority encoder, a multi-match flag and a free-slot finder.
- Search is a 2-stage pipeline with a valid strobe, so results can be consumed back-to-back.
- Sits beside the datapath as a tag/lookup store.

---
 rtl/cam_param_if.sv | 39 +++
 rtl/cam_param.sv | 116 +++++++++++
 tb/tb_cam_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_param_if.sv
// Command and result bundle for cam_param.
// Defining CAM_PARAM_MASK_EN adds the srch_mask field.
interface cam_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              inv_en;
  logic              flush;
  logic              srch_en;
  logic [DATA_W-1:0] srch_key;
`ifdef CAM_PARAM_MASK_EN
  logic [DATA_W-1:0] srch_mask;
`endif
  logic              res_valid;
  logic              res_found;
  logic              res_multi;
  logic [ADDR_W-1:0] res_addr;
  logic [ADDR_W-1:0] free_addr;
  logic              full;

  modport master (
    output wr_en, wr_addr, wr_data, inv_en, flush, srch_en, srch_key,
`ifdef CAM_PARAM_MASK_EN
    output srch_mask,
`endif
    input  res_valid, res_found, res_multi, res_addr, free_addr, full
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, inv_en, flush, srch_en, srch_key,
`ifdef CAM_PARAM_MASK_EN
    input  srch_mask,
`endif
    output res_valid, res_found, res_multi, res_addr, free_addr, full
  );
endinterface

// File: rtl/cam_param.sv
// Parametrised search CAM with valid bits, 2-stage search pipeline and free-slot finder.
// Defining CAM_PARAM_MASK_EN enables the per-bit search mask.
module cam_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic      clk,
  input logic      rst,
  cam_param_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              addr_ok;
  logic [DATA_W-1:0] mask;

  logic [DEPTH-1:0]  match_p0;
  logic [DEPTH-1:0]  match_p1;
  logic              vld_p1;
  logic              vld_p2;
  logic              found_p2;
  logic              multi_p2;
  logic [ADDR_W-1:0] addr_p2;

  logic [ADDR_W-1:0] free_addr_q;
  logic              full_q;

  function automatic logic [ADDR_W-1:0] lowest_set(input logic [DEPTH-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_set(input logic [DEPTH-1:0] v);
    return (v & (v - DEPTH'(1))) != '0;
  endfunction

  assign addr_ok = (int'(bus.wr_addr) < DEPTH);

`ifdef CAM_PARAM_MASK_EN
  assign mask = bus.srch_mask;
`else
  assign mask = '1;
`endif

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && bus.wr_en && addr_ok)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush)
      valid <= '0;
    else if (bus.wr_en && addr_ok)
      valid[bus.wr_addr] <= 1'b1;
    else if (bus.inv_en && addr_ok)
      valid[bus.wr_addr] <= 1'b0;
  end

  always_comb begin
    match_p0 = '0;
    for (int i = 0; i < DEPTH; i++)
      match_p0[i] = valid[i] & (((mem[i] ^ bus.srch_key) & mask) == '0);
  end

  // Stage 1: capture the match vector against pre-edge contents
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      match_p1 <= '0;
    end else begin
      vld_p1 <= bus.srch_en;
      if (bus.srch_en) match_p1 <= match_p0;
    end
  end

  // Stage 2: priority encode; results hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      found_p2 <= 1'b0;
      multi_p2 <= 1'b0;
      addr_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        found_p2 <= |match_p1;
        multi_p2 <= multi_set(match_p1);
        addr_p2  <= lowest_set(match_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_addr_q <= '0;
      full_q      <= 1'b0;
    end else begin
      free_addr_q <= lowest_set(~valid);
      full_q      <= &valid;
    end
  end

  assign bus.res_valid = vld_p2;
  assign bus.res_found = found_p2;
  assign bus.res_multi = multi_p2;
  assign bus.res_addr  = addr_p2;
  assign bus.free_addr = free_addr_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_cam_param.sv
// Directed self-checking bench for cam_param (DEPTH=16, DATA_W=8).
// Mask vectors run only when CAM_PARAM_MASK_EN is defined.
module tb_cam_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
`ifdef CAM_PARAM_MASK_EN
  logic [DATA_W-1:0] cur_mask = 8'hFF;
`endif

  cam_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic inv(input int addr);
    bus.inv_en  = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    tick();
    bus.inv_en = 1'b0;
  endtask

  task automatic do_search(input string tag, input logic [DATA_W-1:0] key,
                           input logic ef, input int ea, input logic em);
    bus.srch_en  = 1'b1;
    bus.srch_key = key;
`ifdef CAM_PARAM_MASK_EN
    bus.srch_mask = cur_mask;
`endif
    tick();
    bus.srch_en = 1'b0;
    check({tag, "_early"}, 32'(bus.res_valid), 0);
    tick();
    check({tag, "_vld"}, 32'(bus.res_valid), 1);
    check({tag, "_found"}, 32'(bus.res_found), 32'(ef));
    check({tag, "_addr"}, 32'(bus.res_addr), ea);
    check({tag, "_multi"}, 32'(bus.res_multi), 32'(em));
    tick();
    check({tag, "_strobe"}, 32'(bus.res_valid), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] keys [3];
    logic              exp_f [3];
    int                exp_a [3];

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.inv_en = 1'b0; bus.flush = 1'b0;
    bus.srch_en = 1'b0; bus.srch_key = '0;
`ifdef CAM_PARAM_MASK_EN
    bus.srch_mask = 8'hFF;
`endif

    // Reset, then search an empty CAM
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_vld", 32'(bus.res_valid), 0);
    check("rst_found", 32'(bus.res_found), 0);
    check("rst_multi", 32'(bus.res_multi), 0);
    check("rst_addr", 32'(bus.res_addr), 0);
    check("rst_free", 32'(bus.free_addr), 0);
    check("rst_full", 32'(bus.full), 0);
    do_search("empty", 8'h00, 1'b0, 0, 1'b0);

    // Write and back-to-back lookups
    wr(3, 8'hA5);
    wr(9, 8'h5A);
    keys[0] = 8'h5A; exp_f[0] = 1'b1; exp_a[0] = 9;
    keys[1] = 8'hA5; exp_f[1] = 1'b1; exp_a[1] = 3;
    keys[2] = 8'h77; exp_f[2] = 1'b0; exp_a[2] = 0;
    for (int k = 0; k < 5; k++) begin
      bus.srch_en = (k < 3);
      if (k < 3) bus.srch_key = keys[k];
      tick();
      if (k >= 1 && k <= 3) begin
        check($sformatf("b2b%0d_vld", k - 1), 32'(bus.res_valid), 1);
        check($sformatf("b2b%0d_found", k - 1), 32'(bus.res_found), 32'(exp_f[k-1]));
        check($sformatf("b2b%0d_addr", k - 1), 32'(bus.res_addr), exp_a[k-1]);
      end
      if (k == 4) check("b2b_strobe", 32'(bus.res_valid), 0);
    end

    // Multi-match and priority
    wr(12, 8'h3C);
    wr(4, 8'h3C);
    wr(7, 8'h3C);
    do_search("multi", 8'h3C, 1'b1, 4, 1'b1);
    inv(4);
    inv(7);
    do_search("multi_inv", 8'h3C, 1'b1, 12, 1'b0);

    // Search in the same cycle as a write sees old contents
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'h11;
    bus.srch_en = 1'b1; bus.srch_key = 8'h11;
    tick();
    bus.wr_en = 1'b0; bus.srch_en = 1'b0;
    tick();
    check("haz_vld", 32'(bus.res_valid), 1);
    check("haz_found", 32'(bus.res_found), 0);
    tick();
    do_search("haz_next", 8'h11, 1'b1, 2, 1'b0);

    // Flush beats write
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'h22; bus.flush = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.flush = 1'b0;
    tick();
    check("flush_full", 32'(bus.full), 0);
    check("flush_free", 32'(bus.free_addr), 0);
    do_search("flush_wr", 8'h22, 1'b0, 0, 1'b0);
    do_search("flush_old", 8'h11, 1'b0, 0, 1'b0);

    // Fill every entry; free_addr lags valid by one cycle
    for (int i = 0; i < DEPTH; i++) begin
      wr(i, 8'h40 + 8'(i));
      check($sformatf("fill%0d_lag", i), 32'(bus.free_addr), i);
      tick();
      check($sformatf("fill%0d_free", i), 32'(bus.free_addr), (i < DEPTH - 1) ? i + 1 : 0);
      check($sformatf("fill%0d_full", i), 32'(bus.full), (i == DEPTH - 1) ? 1 : 0);
    end

    // Invalidate right after a search is accepted does not affect it
    bus.srch_en = 1'b1; bus.srch_key = 8'h42;
    tick();
    bus.srch_en = 1'b0;
    bus.inv_en = 1'b1; bus.wr_addr = 4'd2;
    tick();
    bus.inv_en = 1'b0;
    check("late_inv_found", 32'(bus.res_found), 1);
    check("late_inv_addr", 32'(bus.res_addr), 2);
    tick();
    check("late_inv_free", 32'(bus.free_addr), 2);
    wr(2, 8'h42);
    tick();
    check("refill_full", 32'(bus.full), 1);

    inv(6);
    tick();
    check("inv6_full", 32'(bus.full), 0);
    check("inv6_free", 32'(bus.free_addr), 6);

    // Write beats invalidate on the same entry
    bus.wr_en = 1'b1; bus.inv_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 8'h66;
    tick();
    bus.wr_en = 1'b0; bus.inv_en = 1'b0;
    tick();
    check("wrinv_full", 32'(bus.full), 1);
    do_search("wrinv_new", 8'h66, 1'b1, 6, 1'b0);
    do_search("wrinv_old", 8'h46, 1'b0, 0, 1'b0);

    // Reset while a search is in flight drops it
    bus.srch_en = 1'b1; bus.srch_key = 8'h41;
    tick();
    bus.srch_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_vld0", 32'(bus.res_valid), 0);
    check("rstmid_found", 32'(bus.res_found), 0);
    check("rstmid_full", 32'(bus.full), 0);
    tick();
    check("rstmid_vld1", 32'(bus.res_valid), 0);
    check("rstmid_free", 32'(bus.free_addr), 0);
    do_search("rstmid_gone", 8'h41, 1'b0, 0, 1'b0);

`ifdef CAM_PARAM_MASK_EN
    wr(1, 8'hA0);
    wr(5, 8'hAF);
    cur_mask = 8'hF0;
    do_search("mask_f0", 8'hA3, 1'b1, 1, 1'b1);
    cur_mask = 8'hFF;
    do_search("mask_ff", 8'hA3, 1'b0, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
